// File: rtl/thermo_pkg.sv
// Shared definitions for the thermometer capture front end and the
// downstream thermometer-to-binary encoder.
package thermo_pkg;

   // Thermometer word width and the matching binary code width
   localparam int THERMO_W = 7;
   localparam int BIN_W    = 3;

   // One thermometer word as seen by the encoder
   typedef logic [THERMO_W-1:0] thermo_t;

   // Occupancy of the single-entry output slot
   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

   // True when the word is a legal thermometer code: a run of ones from
   // bit 0 upward with only zeros above it (all-zero is legal too).
   // Adding one to such a word never overlaps any of its set bits.
   function automatic logic is_thermo(input thermo_t word);
      logic [THERMO_W:0] ext;
      logic [THERMO_W:0] inc;
      ext = {1'b0, word};
      inc = ext + 1'b1;
      return ((ext & inc) == '0);
   endfunction

endpackage

// File: rtl/thermo_bubble_fix.sv
// Combinational bubble remover: a three-tap majority vote along the word
// followed by a prefix-AND from bit 0, so the result is always a legal
// thermometer code. err flags words that had to be changed.
module thermo_bubble_fix #(
   parameter int WIDTH = 7
) (
   input  logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] c,
   output logic             err
);

   logic [WIDTH+1:0] ext;
   logic [WIDTH-1:0] m;
   logic             acc;

   // Pad the word so bit 0 sees a one below it and the top bit a zero above
   assign ext = {1'b0, s, 1'b1};

   // Majority of each bit and its two neighbours removes isolated bubbles
   always_comb begin
      m = '0;
      for (int k = 0; k < WIDTH; k++) begin
         m[k] = (ext[k]   & ext[k+1]) |
                (ext[k]   & ext[k+2]) |
                (ext[k+1] & ext[k+2]);
      end
   end

   // Prefix-AND clears everything above the first zero left by the vote
   always_comb begin
      c   = '0;
      acc = 1'b1;
      for (int k = 0; k < WIDTH; k++) begin
         acc  = acc & m[k];
         c[k] = acc;
      end
   end

   assign err = (c != s);

endmodule

// File: rtl/thermo_capture.sv
// Capture stage ahead of the thermometer encoder: synchronises the raw
// comparator bank, samples it every DIV clocks, repairs bubbles and hands
// one word per sample downstream through a single-entry valid/ready slot.
// Samples arriving while the slot is still held are dropped and counted.
module thermo_capture
   import thermo_pkg::*;
#(
   parameter int WIDTH       = 7,
   parameter int SYNC_STAGES = 2,
   parameter int DIV         = 4,
   parameter int DROP_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  comp_in,
   input  logic              sample_en,
   output logic [WIDTH-1:0]  thermo_out,
   output logic              thermo_valid,
   input  logic              thermo_ready,
   output logic              bubble_err,
   output logic              overrun,
   output logic [DROP_W-1:0] drop_cnt
);

   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

   // Synchroniser chain; the last stage is the word the sampler sees
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_d [SYNC_STAGES];
   logic [WIDTH-1:0] sync_word;

   // Sample divider
   logic [DIV_W-1:0] div_cnt_q;
   logic [DIV_W-1:0] div_cnt_d;
   logic             tick;

   // Corrected word from the bubble fixer
   logic [WIDTH-1:0] fix_c;
   logic             fix_err;

   // Output slot and drop accounting
   slot_state_t      slot_q;
   slot_state_t      slot_d;
   logic [WIDTH-1:0] thermo_out_q;
   logic [WIDTH-1:0] thermo_out_d;
   logic             bubble_err_q;
   logic             bubble_err_d;
   logic             overrun_q;
   logic             overrun_d;
   logic [DROP_W-1:0] drop_cnt_q;
   logic [DROP_W-1:0] drop_cnt_d;
   logic             load;
   logic             drop;
   logic             consume;

   // Shift the raw comparator word one stage further down the chain
   always_comb begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
         sync_d[i] = '0;
      end
      sync_d[0] = comp_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   // Synchroniser flops, cleared by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
      end
   end

   assign sync_word = sync_q[SYNC_STAGES-1];

   // Divider counts enabled cycles and ticks on the last one of each period;
   // dropping sample_en restarts the period from zero
   always_comb begin
      tick      = sample_en && (div_cnt_q == DIV_LAST);
      div_cnt_d = div_cnt_q;
      if (!sample_en || tick) begin
         div_cnt_d = '0;
      end else begin
         div_cnt_d = div_cnt_q + 1'b1;
      end
   end

   // Divider counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

   thermo_bubble_fix #(
      .WIDTH (WIDTH)
   ) u_fix (
      .s   (sync_word),
      .c   (fix_c),
      .err (fix_err)
   );

   // Slot next state: a tick loads whenever the slot is free or being
   // emptied this cycle, otherwise it is dropped; ready alone just empties.
   // Ready only reaches registers, so there is no ready-to-valid path.
   always_comb begin
      load    = tick && ((slot_q == SLOT_EMPTY) || thermo_ready);
      drop    = tick && (slot_q == SLOT_FULL) && !thermo_ready;
      consume = (slot_q == SLOT_FULL) && thermo_ready && !tick;

      slot_d       = slot_q;
      thermo_out_d = thermo_out_q;
      bubble_err_d = bubble_err_q;
      overrun_d    = drop;
      drop_cnt_d   = drop_cnt_q;

      if (load) begin
         slot_d       = SLOT_FULL;
         thermo_out_d = fix_c;
         bubble_err_d = fix_err;
      end else if (consume) begin
         slot_d = SLOT_EMPTY;
      end

      if (drop && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + 1'b1;
      end
   end

   // Slot state machine and its registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q       <= SLOT_EMPTY;
         thermo_out_q <= '0;
         bubble_err_q <= 1'b0;
         overrun_q    <= 1'b0;
         drop_cnt_q   <= '0;
      end else begin
         slot_q       <= slot_d;
         thermo_out_q <= thermo_out_d;
         bubble_err_q <= bubble_err_d;
         overrun_q    <= overrun_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign thermo_valid = (slot_q == SLOT_FULL);
   assign thermo_out   = thermo_out_q;
   assign bubble_err   = bubble_err_q;
   assign overrun      = overrun_q;
   assign drop_cnt     = drop_cnt_q;

endmodule
